// File: rtl/ddr3_ui_arbiter.sv
// Two-requester round-robin arbiter in front of a MIG DDR3 user interface.
// A granted requester gets a fixed-length burst of commands. Each command
// advances the word address by ADDR_UNIT. Read bursts stay open until every
// read beat has come back from the controller.
module ddr3_ui_arbiter #(
  parameter int BURST_LEN = 16,
  parameter int ADDR_UNIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  input  logic        req0,
  input  logic        req0_wr,
  input  logic [29:0] req0_addr,
  input  logic        req1,
  input  logic        req1_wr,
  input  logic [29:0] req1_addr,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        sel,
  output logic        busy,
  input  logic        app_rdy,
  output logic        app_en,
  output logic [2:0]  app_cmd,
  output logic [29:0] app_addr,
  input  logic        app_rd_data_valid,
  output logic        err_unexp
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT_RD} state_t;

  localparam logic [4:0] CNT_LAST   = 5'(BURST_LEN - 1);
  localparam logic [4:0] BURST_FULL = 5'(BURST_LEN);

  state_t      state_q, state_d;
  logic        sel_q, sel_d;
  logic        wr_q, wr_d;
  logic [29:0] base_q, base_d;
  logic [4:0]  cmd_cnt_q, cmd_cnt_d;
  logic [4:0]  rd_cnt_q, rd_cnt_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        app_en_q, app_en_d;
  logic        err_q, err_d;

  logic        accept, last_cmd, read_active, beat_ok, rd_full, pick;
  logic [4:0]  rd_next;

  assign accept      = app_en_q & app_rdy;
  assign last_cmd    = accept & (cmd_cnt_q == CNT_LAST);
  assign read_active = (state_q != S_IDLE) & ~wr_q;
  assign beat_ok     = app_rd_data_valid & read_active & (rd_cnt_q < BURST_FULL);
  assign rd_next     = rd_cnt_q + 5'(beat_ok);
  assign rd_full     = (rd_next == BURST_FULL);

  // State register. The latched direction resets to write so that app_cmd idles at 3'b000.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      wr_q      <= 1'b1;
      base_q    <= '0;
      cmd_cnt_q <= '0;
      rd_cnt_q  <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      app_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wr_q      <= wr_d;
      base_q    <= base_d;
      cmd_cnt_q <= cmd_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      app_en_q  <= app_en_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: arbitration, command issue and read-beat accounting.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    base_d    = base_q;
    cmd_cnt_d = cmd_cnt_q;
    rd_cnt_d  = rd_next;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    app_en_d  = 1'b0;
    err_d     = err_q | (app_rd_data_valid & ~beat_ok);
    pick      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (calib_done && (req0 || req1)) begin
          pick      = (req0 && req1) ? ~sel_q : req1;
          gnt0_d    = ~pick;
          gnt1_d    = pick;
          sel_d     = pick;
          wr_d      = pick ? req1_wr : req0_wr;
          base_d    = pick ? req1_addr : req0_addr;
          cmd_cnt_d = '0;
          rd_cnt_d  = '0;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        app_en_d = 1'b1;
        if (accept) begin
          cmd_cnt_d = cmd_cnt_q + 5'd1;
        end
        if (last_cmd) begin
          app_en_d = 1'b0;
          if (wr_q || rd_full) begin
            done0_d = ~sel_q;
            done1_d = sel_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_RD;
          end
        end
      end
      S_WAIT_RD: begin
        if (rd_full) begin
          done0_d = ~sel_q;
          done1_d = sel_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered pulses plus the address formed from base and command count.
  always_comb begin
    gnt0      = gnt0_q;
    gnt1      = gnt1_q;
    done0     = done0_q;
    done1     = done1_q;
    sel       = sel_q;
    busy      = (state_q != S_IDLE);
    app_en    = app_en_q;
    app_cmd   = wr_q ? 3'b000 : 3'b001;
    app_addr  = base_q + 30'(cmd_cnt_q) * 30'(ADDR_UNIT);
    err_unexp = err_q;
  end

endmodule

// File: tb/tb_ddr3_ui_arbiter.sv
// Directed testbench for ddr3_ui_arbiter with a simple fixed-latency MIG read model.
module tb_ddr3_ui_arbiter;

  localparam int RD_LAT = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        calib_done = 1'b0;
  logic        req0 = 1'b0, req0_wr = 1'b0;
  logic [29:0] req0_addr = '0;
  logic        req1 = 1'b0, req1_wr = 1'b0;
  logic [29:0] req1_addr = '0;
  logic        gnt0, gnt1, done0, done1, sel, busy;
  logic        app_rdy = 1'b0;
  logic        app_en;
  logic [2:0]  app_cmd;
  logic [29:0] app_addr;
  logic        app_rd_data_valid = 1'b0;
  logic        err_unexp;

  int n_checks = 0;
  int n_fail = 0;
  int mem_q[$];
  int neg_cnt = 0;

  ddr3_ui_arbiter #(.BURST_LEN(16), .ADDR_UNIT(8)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done),
    .req0(req0), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req1(req1), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .sel(sel), .busy(busy), .app_rdy(app_rdy), .app_en(app_en),
    .app_cmd(app_cmd), .app_addr(app_addr),
    .app_rd_data_valid(app_rd_data_valid), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  // MIG read model: every accepted read command returns one beat RD_LAT cycles later.
  initial begin : mem_model
    forever begin
      @(negedge clk);
      app_rd_data_valid = 1'b0;
      if (mem_q.size() > 0 && mem_q[0] == neg_cnt) begin
        app_rd_data_valid = 1'b1;
        void'(mem_q.pop_front());
      end
      if (app_en && app_rdy && app_cmd == 3'b001) mem_q.push_back(neg_cnt + RD_LAT);
      neg_cnt++;
    end
  end

  initial begin : watchdog
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    for (int i = 0; i < 200 && (mem_q.size() != 0 || app_rd_data_valid); i++) tick();
    req0 = 1'b0; req1 = 1'b0; app_rdy = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; calib_done = 1'b1; req0 = 1'b1; req0_wr = 1'b0; app_rdy = 1'b1;
    tick();
    tick();
    n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_gnt0: got %b want 0", gnt0); end
    n_checks++; if (app_en !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_app_en: got %b want 0", app_en); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (sel !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sel: got %b want 0", sel); end
    n_checks++; if (err_unexp !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b want 0", err_unexp); end
    n_checks++; if (app_cmd !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_app_cmd: got %b want 000", app_cmd); end
    n_checks++; if (app_addr !== 30'h0) begin n_fail++; $display("[TB] FAIL reset_app_addr: got %h want 0", app_addr); end
    n_checks++; if ({done0, done1} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 00", {done0, done1}); end
    req0 = 1'b0; app_rdy = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_write();
    apply_reset();
    calib_done = 1'b1; req0 = 1'b1; req0_wr = 1'b1; req0_addr = 30'h100; app_rdy = 1'b1;
    tick();
    n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("[TB] FAIL write_gnt: got %b want 10", {gnt0, gnt1}); end
    n_checks++; if (app_en !== 1'b0) begin n_fail++; $display("[TB] FAIL write_en_in_grant: got %b want 0", app_en); end
    req0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      n_checks++; if (app_en !== 1'b1 || app_addr !== 30'h100 + 30'(k * 8)) begin
        n_fail++; $display("[TB] FAIL write_cmd%0d: got en=%b addr=%h want en=1 addr=%h", k, app_en, app_addr, 30'h100 + 30'(k * 8));
      end
      n_checks++; if (app_cmd !== 3'b000 || done0 !== 1'b0) begin
        n_fail++; $display("[TB] FAIL write_cmd%0d_kind: got cmd=%b done0=%b want cmd=000 done0=0", k, app_cmd, done0);
      end
    end
    tick();
    n_checks++; if (done0 !== 1'b1 || app_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL write_done: got done0=%b en=%b busy=%b want 1 0 0", done0, app_en, busy);
    end
    tick();
    n_checks++; if (done0 !== 1'b0 || gnt0 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL write_after_done: got done0=%b gnt0=%b want 0 0", done0, gnt0);
    end
  endtask

  task automatic test_read();
    int acc = 0;
    int beats = 0;
    logic rdy_tgl = 1'b1;
    logic got_done = 1'b0;
    apply_reset();
    calib_done = 1'b1; req1 = 1'b1; req1_wr = 1'b0; req1_addr = 30'h2000;
    tick();
    n_checks++; if ({gnt0, gnt1, sel} !== 3'b011) begin n_fail++; $display("[TB] FAIL read_gnt: got gnt0,gnt1,sel=%b want 011", {gnt0, gnt1, sel}); end
    req1 = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      if (app_en) begin
        n_checks++; if (app_addr !== 30'h2000 + 30'(acc * 8) || app_cmd !== 3'b001) begin
          n_fail++; $display("[TB] FAIL read_cmd%0d: got addr=%h cmd=%b want addr=%h cmd=001", acc, app_addr, app_cmd, 30'h2000 + 30'(acc * 8));
        end
      end
      app_rdy = rdy_tgl;
      if (app_en && app_rdy) acc++;
      rdy_tgl = ~rdy_tgl;
      tick();
      if (app_rd_data_valid) beats++;
      if (beats == 16) begin
        got_done = 1'b1;
        n_checks++; if (done1 !== 1'b1 || busy !== 1'b0) begin
          n_fail++; $display("[TB] FAIL read_done: got done1=%b busy=%b want 1 0", done1, busy);
        end
      end else begin
        n_checks++; if (done1 !== 1'b0) begin n_fail++; $display("[TB] FAIL read_early_done: got done1=%b after %0d beats want 0", done1, beats); end
      end
    end
    n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL read_timeout: got %0d beats want 16", beats); end
    n_checks++; if (acc != 16) begin n_fail++; $display("[TB] FAIL read_cmd_count: got %0d want 16", acc); end
    n_checks++; if (err_unexp !== 1'b0) begin n_fail++; $display("[TB] FAIL read_err: got %b want 0", err_unexp); end
    app_rdy = 1'b0;
  endtask

  task automatic test_round_robin();
    int grants = 0;
    logic exp_owner = 1'b1;
    apply_reset();
    calib_done = 1'b1; app_rdy = 1'b1;
    req0 = 1'b1; req0_wr = 1'b1; req0_addr = 30'h0;
    req1 = 1'b1; req1_wr = 1'b1; req1_addr = 30'h1000;
    for (int c = 0; c < 400 && grants < 4; c++) begin
      tick();
      if (gnt0 || gnt1) begin
        n_checks++; if ({gnt0, gnt1} !== {~exp_owner, exp_owner}) begin
          n_fail++; $display("[TB] FAIL rr_order%0d: got gnt0,gnt1=%b want %b", grants, {gnt0, gnt1}, {~exp_owner, exp_owner});
        end
        grants++;
        exp_owner = ~exp_owner;
      end
      if (done0 || done1) begin
        n_checks++; if ((gnt0 | gnt1) !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_gnt_in_done: got gnt=%b want 0", gnt0 | gnt1); end
      end
    end
    n_checks++; if (grants != 4) begin n_fail++; $display("[TB] FAIL rr_grant_count: got %0d want 4", grants); end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_wrap();
    logic [29:0] exp_a = 30'h3FFFFFC0;
    logic [29:0] addr7 = '0;
    logic [29:0] addr8 = '1;
    logic got_done = 1'b0;
    apply_reset();
    calib_done = 1'b1; req0 = 1'b1; req0_wr = 1'b0; req0_addr = 30'h3FFFFFC0; app_rdy = 1'b1;
    tick();
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_gnt0: got %b want 1", gnt0); end
    req0 = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 7) addr7 = app_addr;
      if (k == 8) addr8 = app_addr;
      n_checks++; if (app_en !== 1'b1 || app_addr !== exp_a) begin
        n_fail++; $display("[TB] FAIL wrap_cmd%0d: got en=%b addr=%h want en=1 addr=%h", k, app_en, app_addr, exp_a);
      end
      exp_a = exp_a + 30'd8;
    end
    n_checks++; if (addr7 !== 30'h3FFFFFF8) begin n_fail++; $display("[TB] FAIL wrap_top: got %h want 3ffffff8", addr7); end
    n_checks++; if (addr8 !== 30'h0) begin n_fail++; $display("[TB] FAIL wrap_zero: got %h want 0", addr8); end
    for (int c = 0; c < 100 && !got_done; c++) begin
      tick();
      if (done0) got_done = 1'b1;
    end
    n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_done_timeout: got no done0 want done0"); end
    n_checks++; if (err_unexp !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_err: got %b want 0", err_unexp); end
    app_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    int dones = 0;
    apply_reset();
    calib_done = 1'b1; req1 = 1'b1; req1_wr = 1'b0; req1_addr = 30'h40; app_rdy = 1'b1;
    tick();
    n_checks++; if (gnt1 !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_gnt1: got %b want 1", gnt1); end
    req1 = 1'b0;
    for (int c = 0; c < 50 && acc < 5; c++) begin
      tick();
      if (app_en) acc++;
    end
    n_checks++; if (acc != 5) begin n_fail++; $display("[TB] FAIL rstmid_cmds: got %0d want 5", acc); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (app_en !== 1'b0 || busy !== 1'b0 || done1 !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rstmid_abandon: got en=%b busy=%b done1=%b want 0 0 0", app_en, busy, done1);
    end
    app_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done0 || done1) dones++;
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("[TB] FAIL rstmid_no_done: got %0d done pulses want 0", dones); end
    n_checks++; if (err_unexp !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_err: got %b want 1", err_unexp); end
  endtask

  task automatic test_calib();
    logic got_done = 1'b0;
    apply_reset();
    calib_done = 1'b0; req0 = 1'b1; req0_wr = 1'b1; req0_addr = 30'h500; app_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (gnt0 !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("[TB] FAIL calib_hold%0d: got gnt0=%b busy=%b want 0 0", c, gnt0, busy);
      end
    end
    calib_done = 1'b1;
    tick();
    n_checks++; if (gnt0 !== 1'b1) begin n_fail++; $display("[TB] FAIL calib_gnt0: got %b want 1", gnt0); end
    req0 = 1'b0;
    tick();
    calib_done = 1'b0;
    for (int c = 0; c < 60 && !got_done; c++) begin
      tick();
      if (done0) got_done = 1'b1;
    end
    n_checks++; if (got_done !== 1'b1) begin n_fail++; $display("[TB] FAIL calib_drop_done: got no done0 want done0"); end
    calib_done = 1'b1;
    app_rdy = 1'b0;
  endtask

  initial begin
    $display("[TB] starting ddr3_ui_arbiter tests");
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_calib();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
